// File: rtl/mmm_ctrl.sv
// Sequencer for a bit-serial Montgomery multiplier datapath: clear, WIDTH iterations, final subtraction.
// Optional abort input is enabled by defining MMM_CTRL_ABORT_EN.
module mmm_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rstb,
    input  logic                       start_i,
    input  logic                       sub_needed_i,
`ifdef MMM_CTRL_ABORT_EN
    input  logic                       abort_i,
`endif
    output logic                       en_o,
    output logic                       rst_mmm_o,
    output logic                       ld_r_o,
    output logic                       lock_o,
    output logic [$clog2(WIDTH):0]     bit_idx_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ITER  = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            abort_pend_q, abort_pend_d;
    logic            abort_s;

    logic            en_q, en_d;
    logic            rst_mmm_q, rst_mmm_d;
    logic            ld_r_q, ld_r_d;
    logic            lock_q, lock_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

`ifdef MMM_CTRL_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    // Next-state and bit-counter logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        abort_pend_d = abort_pend_q;
        case (state_q)
            S_IDLE: begin
                abort_pend_d = 1'b0;
                if (start_i && !abort_s) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                cnt_d = '0;
                if (abort_s) begin
                    state_d      = S_CLEAR;
                    abort_pend_d = 1'b1;
                end else if (abort_pend_q) begin
                    // An aborted operation passes through one clear cycle and then idles.
                    state_d      = S_IDLE;
                    abort_pend_d = 1'b0;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (abort_s) begin
                    state_d      = S_CLEAR;
                    abort_pend_d = 1'b1;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = S_FINAL;
                end else begin
                    state_d = S_ITER;
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_FINAL: begin
                if (abort_s) begin
                    state_d      = S_CLEAR;
                    abort_pend_d = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                cnt_d        = '0;
                abort_pend_d = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    // ld_r in FINAL uses sub_needed_i sampled on the edge entering FINAL.
    always_comb begin
        en_d      = 1'b0;
        rst_mmm_d = 1'b1;
        ld_r_d    = 1'b0;
        lock_d    = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_CLEAR: begin
                rst_mmm_d = 1'b0;
            end
            S_ITER: begin
                en_d   = 1'b1;
                ld_r_d = 1'b1;
            end
            S_FINAL: begin
                en_d   = 1'b1;
                lock_d = 1'b1;
                ld_r_d = sub_needed_i;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            abort_pend_q <= 1'b0;
            en_q         <= 1'b0;
            rst_mmm_q    <= 1'b1;
            ld_r_q       <= 1'b0;
            lock_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            abort_pend_q <= abort_pend_d;
            en_q         <= en_d;
            rst_mmm_q    <= rst_mmm_d;
            ld_r_q       <= ld_r_d;
            lock_q       <= lock_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign en_o      = en_q;
    assign rst_mmm_o = rst_mmm_q;
    assign ld_r_o    = ld_r_q;
    assign lock_o    = lock_q;
    assign bit_idx_o = cnt_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
